// File: rtl/display_sched_pkg.sv
// -----------------------------------------------------------------------------
// display_sched_pkg
// Shared definitions for the seven-segment display source scheduler.
//   DISPLAY_W      width of one display sample
//   SRC_*          conventional source slot assignments
//   sched_state_e  scheduler state encoding
// -----------------------------------------------------------------------------
package display_sched_pkg;

    localparam int DISPLAY_W = 16;

    localparam int SRC_DISTANCE = 0;
    localparam int SRC_ANGLE    = 1;
    localparam int SRC_STRENGTH = 2;
    localparam int SRC_DEBUG    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // nothing captured since reset
        SHOW   = 2'd1,   // active source on the display, dwell running
        SWITCH = 2'd2    // one-cycle hop to the next source with data
    } sched_state_e;

endpackage

// File: rtl/display_source_scheduler_picker.sv
// -----------------------------------------------------------------------------
// rr_next_picker
// Combinational round-robin search: first index after cur_i (wrapping modulo
// NUM_SRC) whose mask bit is set. cur_i itself is only considered last.
//   mask_i   sources that hold data
//   cur_i    currently active index
//   next_o   chosen index (cur_i when no other source qualifies)
//   found_o  high when some other source qualified
// -----------------------------------------------------------------------------
module rr_next_picker #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] mask_i,
    input  logic [SRC_W-1:0]   cur_i,
    output logic [SRC_W-1:0]   next_o,
    output logic               found_o
);

    logic [SRC_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit is the one
    // left standing.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it a
        // path that never matches would infer a latch.
        next_o  = cur_i;
        found_o = 1'b0;
        idx     = cur_i;
        for (int k = NUM_SRC - 1; k >= 1; k--) begin
            idx = SRC_W'((int'(cur_i) + k) % NUM_SRC);
            if (mask_i[idx]) begin
                next_o  = idx;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_source_scheduler.sv
// -----------------------------------------------------------------------------
// display_source_scheduler
// Time-shares the 16-bit seven-segment value among NUM_SRC producers. Each
// source hands samples into a one-entry shadow register over valid/ready;
// the scheduler rotates the shown source on a dwell timer, with a pin
// override, and pulses a trigger when the first sample after reset appears.
//   clk_in, rst_n_in       clock, synchronous active-low reset
//   src_valid_in/_data_in  per-source samples (source i at [16*i+15:16*i])
//   src_ready_out          per-source ready
//   pin_valid_in/sel_in    hold the display on one source while high
//   display_value_out      value to the display controller
//   display_trigger_out    single pulse on the first displayed sample
//   active_src_out         index of the source on the display
//   pinned_out             pin override in effect
// -----------------------------------------------------------------------------
module display_source_scheduler
    import display_sched_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int SRC_W        = $clog2(NUM_SRC)
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic [NUM_SRC-1:0]             src_valid_in,
    input  logic [DISPLAY_W*NUM_SRC-1:0]   src_data_in,
    output logic [NUM_SRC-1:0]             src_ready_out,
    input  logic                           pin_valid_in,
    input  logic [SRC_W-1:0]               pin_sel_in,
    output logic [DISPLAY_W-1:0]           display_value_out,
    output logic                           display_trigger_out,
    output logic [SRC_W-1:0]               active_src_out,
    output logic                           pinned_out
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);

    logic [DISPLAY_W-1:0] src_data [NUM_SRC];
    logic [DISPLAY_W-1:0] shadow_q [NUM_SRC];
    logic [DISPLAY_W-1:0] shadow_d [NUM_SRC];
    logic [NUM_SRC-1:0]   has_data_q, has_data_d;
    logic [NUM_SRC-1:0]   fresh_q, fresh_d;
    logic [NUM_SRC-1:0]   hs;
    sched_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SRC_W-1:0]     active_q, active_d;
    logic [DISPLAY_W-1:0] disp_q, disp_d;
    logic                 trig_q, trig_d;
    logic                 pinned_q, pinned_d;
    logic [SRC_W-1:0]     first_idx, next_idx, load_idx;
    logic                 next_found, load_en, pin_ok;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_data[g] = src_data_in[DISPLAY_W*g +: DISPLAY_W];
    end

    // A non-active source with an undisplayed sample is back-pressured; the
    // active source may always overwrite since it is mirrored on the display.
    assign src_ready_out = ~fresh_q
                         | ((state_q == SHOW) ? (NUM_SRC'(1) << active_q) : '0);
    assign hs = src_valid_in & src_ready_out;

    // Out-of-range or empty pins are ignored; the && short-circuits the
    // has_data lookup when the index is out of range.
    assign pin_ok = pin_valid_in && (int'(pin_sel_in) < NUM_SRC)
                    && has_data_q[pin_sel_in];

    rr_next_picker #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_picker (
        .mask_i  (has_data_q),
        .cur_i   (active_q),
        .next_o  (next_idx),
        .found_o (next_found)
    );

    // Lowest-index handshake wins the very first display slot.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (hs[i]) first_idx = SRC_W'(i);
        end
    end

    always_comb begin
        shadow_d   = shadow_q;
        has_data_d = has_data_q;
        fresh_d    = fresh_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        disp_d     = disp_q;
        trig_d     = 1'b0;
        pinned_d   = 1'b0;
        load_en    = 1'b0;
        load_idx   = active_q;

        for (int i = 0; i < NUM_SRC; i++) begin
            if (hs[i]) begin
                shadow_d[i]   = src_data[i];
                has_data_d[i] = 1'b1;
                fresh_d[i]    = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (|hs) begin
                    state_d  = SHOW;
                    active_d = first_idx;
                    load_en  = 1'b1;
                    load_idx = first_idx;
                    trig_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            SHOW: begin
                // Reloading the active slot every cycle gives the 1-cycle
                // pass-through of active-source samples for free.
                load_en = 1'b1;
                if (pin_ok) begin
                    active_d = pin_sel_in;
                    load_idx = pin_sel_in;
                    cnt_d    = '0;
                    pinned_d = 1'b1;
                end else if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                    state_d = SWITCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SWITCH: begin
                state_d = SHOW;
                cnt_d   = '0;
                load_en = 1'b1;
                if (pin_ok) begin
                    active_d = pin_sel_in;
                    load_idx = pin_sel_in;
                    pinned_d = 1'b1;
                end else begin
                    active_d = next_found ? next_idx : active_q;
                    load_idx = next_found ? next_idx : active_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // A sample arriving in the same cycle it is selected goes straight
        // to the display rather than the stale shadow.
        if (load_en) begin
            disp_d            = hs[load_idx] ? src_data[load_idx] : shadow_q[load_idx];
            fresh_d[load_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            // NOTE: the shadows are reset too: a source pinned or rotated to
            // before it ever loaded must not put stale data on the display.
            shadow_q   <= '{default: '0};
            has_data_q <= '0;
            fresh_q    <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            active_q   <= '0;
            disp_q     <= '0;
            trig_q     <= 1'b0;
            pinned_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the next-state logic.
            shadow_q   <= shadow_d;
            has_data_q <= has_data_d;
            fresh_q    <= fresh_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            disp_q     <= disp_d;
            trig_q     <= trig_d;
            pinned_q   <= pinned_d;
        end
    end

    assign display_value_out   = disp_q;
    assign display_trigger_out = trig_q;
    assign active_src_out      = active_q;
    assign pinned_out          = pinned_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_source_scheduler
// Directed bench for display_source_scheduler with NUM_SRC=4, DWELL_CYCLES=8.
// Inputs change and outputs are sampled on the falling edge; every step below
// advances a known number of rising edges, so expected values are fixed by
// cycle arithmetic (one dwell = 8 SHOW cycles + 1 SWITCH cycle).
// -----------------------------------------------------------------------------
module tb_display_source_scheduler;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_SRC-1:0]    src_valid;
    logic [15:0]           data [NUM_SRC];
    logic [16*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]    src_ready;
    logic                  pin_valid;
    logic [SRC_W-1:0]      pin_sel;
    logic [15:0]           disp;
    logic                  trig;
    logic [SRC_W-1:0]      active;
    logic                  pinned;

    int n_cmp     = 0;
    int n_bad     = 0;
    int trig_seen = 0;

    always #5 clk = ~clk;

    assign src_data = {data[3], data[2], data[1], data[0]};

    display_source_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DWELL_CYCLES (8)
    ) dut (
        .clk_in              (clk),
        .rst_n_in            (rst_n),
        .src_valid_in        (src_valid),
        .src_data_in         (src_data),
        .src_ready_out       (src_ready),
        .pin_valid_in        (pin_valid),
        .pin_sel_in          (pin_sel),
        .display_value_out   (disp),
        .display_trigger_out (trig),
        .active_src_out      (active),
        .pinned_out          (pinned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing on the following falling edge, and
    // count every trigger pulse seen on the way.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (trig === 1'b1) trig_seen++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        src_valid = '0;
        pin_valid = 1'b0;
        pin_sel   = '0;
        for (int i = 0; i < NUM_SRC; i++) data[i] = '0;

        // Reset state
        tick(2);
        check("rst_disp",   disp,      16'h0);
        check("rst_trig",   trig,      1'b0);
        check("rst_active", active,    2'd0);
        check("rst_pinned", pinned,    1'b0);
        check("rst_ready",  src_ready, 4'hF);

        // First capture from source 1 triggers the display
        rst_n     = 1'b1;
        src_valid = 4'b0010;
        data[1]   = 16'h0042;
        tick(1);
        check("t1_trig",   trig,   1'b1);
        check("t1_active", active, 2'd1);
        check("t1_disp",   disp,   16'h0042);
        // Pin to a source without data is ignored
        src_valid = '0;
        pin_valid = 1'b1;
        pin_sel   = 2'd2;
        tick(1);
        check("t1_trig_once", trig, 1'b0);
        // Two dwell expiries with a single source: stays on source 1
        tick(20);
        check("t1_hold_active", active,    2'd1);
        check("t1_pin_ignored", pinned,    1'b0);
        check("t1_hold_disp",   disp,      16'h0042);
        check("t1_trig_count",  trig_seen, 1);
        pin_valid = 1'b0;

        // Fresh epoch: rotation over sources 0, 1, 3
        rst_n = 1'b0;
        tick(1);
        rst_n     = 1'b1;
        trig_seen = 0;
        src_valid = 4'b1011;
        data[0]   = 16'h1111;
        data[1]   = 16'h2222;
        data[3]   = 16'h4444;
        tick(1);
        check("t2_disp0",   disp,      16'h1111);
        check("t2_active0", active,    2'd0);
        check("t2_ready",   src_ready, 4'b0101);
        src_valid = '0;
        tick(8);
        check("t2_switch_disp", disp,   16'h1111);
        check("t2_switch_act",  active, 2'd0);
        tick(1);
        check("t2_disp1",   disp,   16'h2222);
        check("t2_active1", active, 2'd1);
        tick(8);
        check("t2_hold1", disp, 16'h2222);
        tick(1);
        check("t2_disp3",   disp,   16'h4444);
        check("t2_active3", active, 2'd3);
        tick(9);
        check("t2_wrap_disp",   disp,   16'h1111);
        check("t2_wrap_active", active, 2'd0);

        // Active source 0 streams three samples
        src_valid = 4'b0001;
        data[0]   = 16'h0001;
        tick(1);
        check("t3_s1",    disp,         16'h0001);
        check("t3_rdy1",  src_ready[0], 1'b1);
        data[0] = 16'h0002;
        tick(1);
        check("t3_s2",    disp,         16'h0002);
        check("t3_rdy2",  src_ready[0], 1'b1);
        data[0] = 16'h0003;
        tick(1);
        check("t3_s3",    disp,         16'h0003);
        check("t3_rdy3",  src_ready[0], 1'b1);

        // Non-active source 2: AAAA held until shown, BBBB waits
        src_valid = 4'b0100;
        data[2]   = 16'hAAAA;
        tick(1);
        check("t4_ready_blk", src_ready, 4'b1011);
        check("t4_disp_keep", disp,      16'h0003);
        data[2] = 16'hBBBB;
        tick(13);
        check("t4_disp_s1",   disp,         16'h2222);
        check("t4_still_blk", src_ready[2], 1'b0);
        tick(1);
        check("t4_show_aaaa", disp,         16'hAAAA);
        check("t4_active2",   active,       2'd2);
        check("t4_ready_up",  src_ready[2], 1'b1);
        tick(1);
        check("t4_show_bbbb", disp, 16'hBBBB);
        src_valid = '0;

        // Pin to source 3 asserted on the dwell-expiry cycle
        tick(6);
        pin_valid = 1'b1;
        pin_sel   = 2'd3;
        tick(1);
        check("t5_pin_active", active, 2'd3);
        check("t5_pinned",     pinned, 1'b1);
        check("t5_pin_disp",   disp,   16'h4444);
        tick(50);
        check("t5_hold_active", active, 2'd3);
        check("t5_hold_pinned", pinned, 1'b1);
        pin_valid = 1'b0;
        tick(1);
        check("t5_released", pinned, 1'b0);
        check("t5_rel_act",  active, 2'd3);
        tick(7);
        check("t5_dwell_end", active, 2'd3);
        tick(1);
        check("t5_resume_act",  active, 2'd0);
        check("t5_resume_disp", disp,   16'h0003);
        tick(9);
        check("t5_next_act",  active,    2'd1);
        check("t5_next_disp", disp,      16'h2222);
        check("t5_trig_once", trig_seen, 1);

        // Reset mid-dwell aborts to IDLE
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("t6_disp",   disp,      16'h0);
        check("t6_active", active,    2'd0);
        check("t6_ready",  src_ready, 4'hF);
        check("t6_pinned", pinned,    1'b0);
        check("t6_trig",   trig,      1'b0);
        rst_n     = 1'b1;
        trig_seen = 0;
        tick(3);
        check("t6_idle_disp", disp,      16'h0);
        check("t6_idle_trig", trig_seen, 0);
        src_valid = 4'b0100;
        data[2]   = 16'h5A5A;
        tick(1);
        check("t6_retrig",     trig,   1'b1);
        check("t6_new_active", active, 2'd2);
        check("t6_new_disp",   disp,   16'h5A5A);
        src_valid = '0;
        tick(1);
        check("t6_trig_low",   trig,      1'b0);
        check("t6_trig_count", trig_seen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
Time-shares the single 16-bit seven-segment display value among NUM_SRC producers, such as distance, angle, signal strength and debug.
- Each source delivers samples over a valid/ready handshake into a one-entry shadow register.
- The scheduler rotates the displayed source round-robin on a dwell timer, with an operator pin override.
- It drives the display controller's distance and trigger inputs and sits between the sensing datapath and the seven-segment controller.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DWELL_CYCLES, 100_000_000, clock cycles each source stays on the display during rotation (1 s at 100 MHz); minimum 2
SRC_W, $clog2(NUM_SRC), width of source index

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  synchronous, active-low reset
src_valid_in  input  NUM_SRC  per-source sample valid
src_data_in  input  16*NUM_SRC  flattened samples; source i occupies bits [16*i+15:16*i]
src_ready_out  output  NUM_SRC  per-source ready
pin_valid_in  input  1  hold the display on pin_sel_in while high
pin_sel_in  input  SRC_W  source index to pin
display_value_out  output  16  value to the display controller's distance input
display_trigger_out  output  1  one-cycle pulse; display controller leaves LOADING
active_src_out  output  SRC_W  source currently shown
pinned_out  output  1  high while the pin override is in effect

Behaviour:
- Reset is sampled on the clock edge only. While rst_n_in is low:
  - all shadow registers, has_data and fresh bits clear
  - state = IDLE, dwell counter = 0
  - display_value_out = 0, display_trigger_out = 0, active_src_out = 0, pinned_out = 0
  - src_ready_out = all ones
- Per-source capture:
  - Handshake on source i occurs when src_valid_in[i] and src_ready_out[i] are both high.
  - On a handshake, shadow[i] is loaded next edge, has_data[i] is set (sticky until reset), and fresh[i] is set.
- src_ready_out[i] = ~fresh[i] OR (i == active_src_out and state == SHOW). An undisplayed sample of a non-active source is never overwritten.
- States:
  - IDLE: no has_data bit set.
    - Stay while none is set.
    - On the first capture from any source j, go to SHOW next cycle: active = j (lowest index if simultaneous), display_value_out = that sample, fresh[j] cleared, display_trigger_out pulses for exactly that one cycle.
    - The trigger fires once per reset.
  - SHOW:
    - If the active source handshakes in cycle t, display_value_out = new sample at t+1 (1-cycle latency) and fresh stays clear.
    - The dwell counter increments each cycle while not pinned.
    - At count DWELL_CYCLES-1, go to SWITCH and reset the counter to 0.
  - SWITCH (exactly 1 cycle):
    - next = first index after active, wrapping modulo NUM_SRC, with has_data set.
    - If no other source has data, next = active.
    - Next cycle: return to SHOW with active = next, display_value_out = shadow[next], fresh[next] cleared, counter = 0.
- Pin override:
  - Applies when pin_valid_in is high, pin_sel_in < NUM_SRC and has_data[pin_sel_in].
  - In SHOW or SWITCH the next state is SHOW, active = pin_sel_in (loaded as in SWITCH when it differs), counter held at 0, pinned_out = 1.
  - An invalid pin is ignored and rotation continues.
  - When the pin is released, rotation resumes from the pinned source with a fresh dwell.
  - Pin wins over a simultaneous dwell expiry.
- Simultaneous handshakes from several sources in one cycle are all accepted into their own shadows.
- Synchronous reset asserted mid-dwell or mid-SWITCH aborts immediately to IDLE. Pin is not honoured in IDLE.

Decomposition:
- Package display_sched_pkg holds:
  - state enum {IDLE, SHOW, SWITCH}
  - source index constants SRC_DISTANCE=0, SRC_ANGLE=1, SRC_STRENGTH=2, SRC_DEBUG=3
  - DISPLAY_W=16
- One sub-module: rr_next_picker, combinational. Takes the has_data mask and current index and returns the next index plus a found flag.

Test Plan:
1. Reset, then src_valid[1] with data 16'h0042 -> trigger pulses exactly 1 cycle, active_src=1, display_value_out=16'h0042 the next cycle; no further trigger for the rest of the run.
2. DWELL_CYCLES=8, sources 0, 1 and 3 loaded with 16'h1111, 16'h2222, 16'h4444 -> display sequence 1111, 2222, 4444, 1111, each held 8 cycles plus 1 SWITCH cycle; source 2 is skipped.
3. Active source 0 streams 16'h0001, 16'h0002, 16'h0003 on consecutive cycles -> each appears on display_value_out 1 cycle after its handshake; src_ready_out[0] stays high throughout.
4. Non-active source 2 sends 16'hAAAA, then holds valid with 16'hBBBB -> src_ready_out[2]=0 until source 2 is shown; display shows AAAA first, then ready rises and BBBB is accepted.
5. pin_valid=1 with pin_sel=3 (has data) asserted on the dwell-expiry cycle -> active=3, pinned_out=1, no rotation for 50 cycles; release -> rotation resumes from 3 to 0 after 8 cycles. pin_sel=2 without data -> ignored.
6. rst_n_in driven low mid-dwell -> next edge: display_value_out=0, active=0, ready all ones, state IDLE. A new capture after reset retriggers display_trigger_out.
